// File: rtl/prog_loader_pkg.sv
// ==== prog_loader_pkg : shared widths and loader state encoding (rev 1.0) ====
`default_nettype none

package prog_loader_pkg;

  localparam int DEF_CNTR_WIDTH    = 8;
  localparam int DEF_ADDR_WIDTH    = 5;
  localparam int DEF_UNDEFINED     = 3;
  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_COMBINED_DATA = DEF_ADDR_WIDTH + DEF_UNDEFINED + DEF_DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } ld_state_e;

  function automatic int bytes_per_word(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/loader_word_asm.sv
// ==== loader_word_asm : MSB-first byte-to-word assembler (rev 1.0) ====
`default_nettype none

module loader_word_asm
  import prog_loader_pkg::*;
#(
  parameter int COMBINED_DATA = DEF_COMBINED_DATA
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     byte_en_i,
  input  logic [7:0]               byte_i,
  output logic [COMBINED_DATA-1:0] word_o,
  output logic                     word_done_o
);

  localparam int NBYTES = bytes_per_word(COMBINED_DATA);
  localparam int PREVW  = (NBYTES > 1) ? (NBYTES - 1) * 8 : 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  // Only the earlier bytes of a word are stored; the final byte is used directly.
  logic [PREVW-1:0]   shift_q, shift_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [PREVW+7:0]   cat_w;

  assign cat_w       = {shift_q, byte_i};
  assign word_o      = cat_w[COMBINED_DATA-1:0];
  assign word_done_o = byte_en_i && (idx_q == LAST_IDX);

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear_i) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (byte_en_i) begin
      shift_d = cat_w[PREVW-1:0];
      idx_d   = word_done_o ? '0 : idx_q + IDXW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ==== prog_loader : host byte-stream program loader with checksum and core hold (rev 1.0) ====
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CNTR_WIDTH    = DEF_CNTR_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int UNDEFINED     = DEF_UNDEFINED,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int COMBINED_DATA = ADDR_WIDTH + UNDEFINED + DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     mem_we,
  output logic [CNTR_WIDTH-1:0]    mem_addr,
  output logic [COMBINED_DATA-1:0] mem_wdata,
  output logic                     core_rst_n,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  ld_state_e                state_q, state_d;
  logic [7:0]               hdr_q, hdr_d;
  logic [7:0]               wcnt_q, wcnt_d;
  logic [7:0]               csum_q, csum_d;
  logic [CNTR_WIDTH-1:0]    addr_q, addr_d;
  logic                     we_q, we_d;
  logic [COMBINED_DATA-1:0] wdata_q, wdata_d;

  logic                     accept_w;
  logic                     asm_clear_w;
  logic                     asm_en_w;
  logic                     word_done_w;
  logic [COMBINED_DATA-1:0] word_w;

  assign byte_ready = (state_q == ST_HDR) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  assign busy       = byte_ready;
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);
  assign core_rst_n = (state_q == ST_DONE);
  assign accept_w   = byte_valid && byte_ready;
  assign asm_en_w   = accept_w && (state_q == ST_PAYLOAD);

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  loader_word_asm #(
    .COMBINED_DATA (COMBINED_DATA)
  ) u_word_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (asm_clear_w),
    .byte_en_i   (asm_en_w),
    .byte_i      (byte_data),
    .word_o      (word_w),
    .word_done_o (word_done_w)
  );

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    wcnt_d      = wcnt_q;
    csum_d      = csum_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    asm_clear_w = 1'b0;

    // Advance after each write, saturating so the final word never wraps to 0.
    if (we_q && (addr_q != {CNTR_WIDTH{1'b1}})) begin
      addr_d = addr_q + CNTR_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d     = ST_HDR;
          csum_d      = '0;
          addr_d      = '0;
          wcnt_d      = '0;
          asm_clear_w = 1'b1;
        end
      end
      ST_HDR: begin
        if (accept_w) begin
          hdr_d   = byte_data;
          csum_d  = csum_q ^ byte_data;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (accept_w) begin
          csum_d = csum_q ^ byte_data;
          if (word_done_w) begin
            we_d    = 1'b1;
            wdata_d = word_w;
            wcnt_d  = wcnt_q + 8'd1;
            if (wcnt_q == hdr_q) begin
              state_d = ST_CHK;
            end
          end
        end
      end
      ST_CHK: begin
        if (accept_w) begin
          state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      wcnt_q  <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      wcnt_q  <= wcnt_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ==== tb_prog_loader : randomized self-checking bench for prog_loader (rev 1.0) ====
`default_nettype none

module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int CW = DEF_COMBINED_DATA;
  localparam int NB = (CW + 7) / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_we;
  logic [7:0]    mem_addr;
  logic [CW-1:0] mem_wdata;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]    addr;
    logic [CW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [CW-1:0] wq[$];

  always #5 clk = ~clk;

  prog_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the next expected (address, word) pair.
  always @(negedge clk) begin : mon
    wr_t e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_value("unexpected_we", 64'(mem_addr), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check_value("we_addr", 64'(mem_addr), 64'(e.addr));
        check_value("we_data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard      = 0;
    while (1) begin
      @(negedge clk);
      if (byte_ready === 1'b1) break;
      guard++;
      if (guard > 100) begin
        check_value("byte_accept_timeout", 64'(byte_ready), 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  // Loads the words in wq; checksum and pass/fail outcome come from the byte stream itself.
  task automatic run_load(input bit use_chk, input logic [7:0] chk_byte, input bit gaps,
                          input bit mid_start, input string tag);
    logic [7:0]    cs;
    logic [7:0]    hb;
    logic [7:0]    b;
    logic [7:0]    cb;
    logic [CW-1:0] w;
    bit            good;
    hb = 8'(wq.size() - 1);
    cs = hb;
    pulse_start();
    send_byte(hb, gaps);
    for (int i = 0; i < wq.size(); i++) begin
      w = wq[i];
      exp_q.push_back('{addr: 8'(i), data: w});
      for (int j = 0; j < NB; j++) begin
        b  = 8'(w >> (8 * (NB - 1 - j)));
        cs = cs ^ b;
        send_byte(b, gaps);
      end
      if (mid_start && i == 0) pulse_start();
    end
    cb   = use_chk ? chk_byte : cs;
    good = (cb == cs);
    send_byte(cb, gaps);
    repeat (2) @(posedge clk);
    #1;
    check_value({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    check_value({tag, "_done"}, 64'(done), 64'(good));
    check_value({tag, "_err"}, 64'(err), 64'(!good));
    check_value({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(good));
    check_value({tag, "_busy"}, 64'(busy), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #1;
    check_value("rst_state_flags", {60'd0, busy, done, err, byte_ready}, 64'd0);
    check_value("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    check_value("rst_mem", {mem_we, 8'(mem_addr), 24'(mem_wdata)}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_value("idle_core_rst_n", 64'(core_rst_n), 64'd0);

    wq.delete(); wq.push_back(24'h123456);
    run_load(1'b1, 8'h70, 1'b0, 1'b0, "single_word");

    wq.delete(); wq.push_back(24'hA1B2C3); wq.push_back(24'h0D0E0F);
    run_load(1'b1, 8'hFF, 1'b0, 1'b0, "bad_check");

    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back(CW'($urandom));
    run_load(1'b0, 8'h00, 1'b1, 1'b0, "full_256");
    check_value("full_256_last_addr", 64'(mem_addr), 64'd255);

    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(CW'($urandom));
    run_load(1'b0, 8'h00, 1'b1, 1'b1, "start_in_payload");

    // Abandon a load partway through word 1; nothing may be written.
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("midrst_flags", {60'd0, busy, done, err, byte_ready}, 64'd0);
    check_value("midrst_core_rst_n", 64'(core_rst_n), 64'd0);
    check_value("midrst_mem", {mem_we, 8'(mem_addr), 24'(mem_wdata)}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back(CW'($urandom));
    run_load(1'b0, 8'h00, 1'b0, 1'b0, "after_reset");

    for (int r = 0; r < 6; r++) begin
      wq.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) wq.push_back(CW'($urandom));
      run_load(($urandom_range(0, 2) == 0), 8'($urandom), 1'b1, 1'b0, "random_load");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter CNTR_WIDTH, default 8, giving the program-memory address width (256 words).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, giving the opcode field width.
REQ-003 The block SHALL have parameter UNDEFINED, default 3, giving the register-select field width.
REQ-004 The block SHALL have parameter DATA_WIDTH, default 16, giving the immediate/data field width.
REQ-005 The block SHALL have parameter COMBINED_DATA, default ADDR_WIDTH+UNDEFINED+DATA_WIDTH (24), giving the instruction word width.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port start, input, 1 bit: single-cycle request to begin a load.
REQ-009 The block SHALL have port byte_valid, input, 1 bit: host byte present.
REQ-010 The block SHALL have port byte_data, input, 8 bits: host byte.
REQ-011 The block SHALL have port byte_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-012 The block SHALL have port mem_we, output, 1 bit: program-memory write strobe.
REQ-013 The block SHALL have port mem_addr, output, CNTR_WIDTH bits: write address.
REQ-014 The block SHALL have port mem_wdata, output, COMBINED_DATA bits: instruction word.
REQ-015 The block SHALL have port core_rst_n, output, 1 bit: active-low hold for the core.
REQ-016 The block SHALL have ports busy, done and err, each output, 1 bit: status.

Function
REQ-017 A byte SHALL transfer only in a cycle where byte_valid and byte_ready are both 1; byte_ready SHALL be 1 exactly in states HDR, PAYLOAD and CHK.
REQ-018 States SHALL be IDLE, HDR, PAYLOAD, CHK, DONE and ERR, with these transitions:
- IDLE/DONE/ERR -> HDR on start.
- HDR -> PAYLOAD on a byte.
- PAYLOAD -> CHK after the last byte of the last word.
- CHK -> DONE or ERR on a byte.
REQ-019 The HDR byte SHALL be word count minus 1 (0..255 meaning 1..256 words) and SHALL be latched.
REQ-020 Each word SHALL be ceil(COMBINED_DATA/8) bytes (3 by default), MSB byte first; bits above COMBINED_DATA SHALL be discarded.
REQ-021 mem_we SHALL pulse high for exactly one cycle, registered, in the cycle after the final byte of a word is accepted; mem_addr and mem_wdata SHALL be stable in that cycle.
REQ-022 mem_addr SHALL start at 0 for each load and SHALL increment by 1 after each write; the 256th write SHALL be at address 255 with no wrap write.
REQ-023 A running checksum SHALL be the XOR of the header and all payload bytes; CHK SHALL go to DONE if the received byte equals the checksum, else to ERR.
REQ-024 core_rst_n SHALL be 1 only in DONE and 0 in every other state, including IDLE after reset.
REQ-025 busy SHALL be 1 in HDR, PAYLOAD and CHK; done SHALL be 1 in DONE; err SHALL be 1 in ERR; these flags SHALL be mutually exclusive.
REQ-026 start SHALL be ignored while busy; start in the same cycle as the CHK byte SHALL be ignored.
REQ-027 The block SHALL apply no timeout; byte_valid low SHALL stall indefinitely with all state held.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, checksum=0, byte index=0, core_rst_n=0, busy=done=err=0, byte_ready=0.
REQ-029 Reset mid-load SHALL abandon the load with no further writes; already-written words SHALL remain in memory.

Structure
REQ-030 The shared package SHALL hold the width defaults (CNTR_WIDTH, ADDR_WIDTH, UNDEFINED, DATA_WIDTH, COMBINED_DATA) and the loader state encoding.
REQ-031 Byte-to-word assembly (shift register plus byte index) SHALL be one sub-module, loader_word_asm; the FSM, address counter and checksum SHALL stay in prog_loader.

Verification
REQ-032 Reset, then start, header 0x00, bytes 0x12,0x34,0x56, check 0x70 -> one mem_we at addr 0 with data 0x123456, then DONE with core_rst_n=1.
REQ-033 Header 0x01, two words, wrong check byte 0xFF -> two writes at addr 0 and 1, then ERR, err=1, core_rst_n=0.
REQ-034 Header 0xFF, 768 payload bytes with random byte_valid gaps -> 256 writes, addresses 0..255 in order, last at 255, then DONE.
REQ-035 start pulsed during PAYLOAD -> no effect; the load completes normally.
REQ-036 rst_n asserted after 2 of 3 bytes of word 1 -> immediate IDLE, no mem_we, core_rst_n=0; a new load then succeeds from addr 0.
